seq_adder: RTL and testbench

SEQ_ADDER -- requirements
Module: seq_adder

---
 rtl/seq_adder_pkg.sv | 25 ++
 rtl/full_adder.sv | 17 +
 rtl/seq_adder.sv | 150 +++++++++++++++
 tb/tb_seq_adder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/seq_adder_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
//   state_e     : controller state encoding (idle, running digits, result pulse)
//   calc_ndig   : number of digits processed per operation (WIDTH / DIGIT)
//   calc_cnt_w  : width of the digit counter, never less than one bit
package seq_adder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefDigit = 2;

  function automatic int unsigned calc_ndig(input int unsigned width, input int unsigned digit);
    return width / digit;
  endfunction

  // A single-digit configuration still needs a one-bit counter.
  function automatic int unsigned calc_cnt_w(input int unsigned ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder, the ripple cell of the digit adder.
//   a_i, b_i : operand bits
//   c_i      : carry in
//   s_o      : sum bit
//   c_o      : carry out
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/seq_adder.sv
// Digit-serial adder/subtractor. Adds DIGIT bits per clock, least-significant
// digit first, and presents the full result with a one-cycle done pulse.
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset
//   start  : begin an operation with a, b, cin, sub (ignored while busy)
//   a, b   : operands
//   cin    : carry-in (add) or borrow-in (subtract)
//   sub    : 0 = a + b + cin, 1 = a - b - cin
//   busy   : operation in progress
//   done   : one-cycle pulse, s/cout/ovf valid
//   s      : result, held until the next operation completes
//   cout   : carry out (subtract: 1 = no borrow)
//   ovf    : signed overflow
// WIDTH must be an integer multiple of DIGIT.
module seq_adder
  import seq_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DIGIT = DefDigit
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NDIG = calc_ndig(WIDTH, DIGIT);
  localparam int unsigned CntW = calc_cnt_w(NDIG);
  localparam logic [CntW-1:0] LastDig = CntW'(NDIG - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;     // already inverted in subtract mode
  logic [WIDTH-1:0] acc_q, acc_d; // partial sum, kept off s until the last digit
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] a_dig, b_dig, sum_dig;
  logic [DIGIT:0]   chain;

  // Select the current digit of both latched operands.
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int unsigned k = 0; k < NDIG; k++) begin
      if (cnt_q == CntW'(k)) begin
        a_dig = a_q[k*DIGIT +: DIGIT];
        b_dig = b_q[k*DIGIT +: DIGIT];
      end
    end
  end

  assign chain[0] = carry_q;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    full_adder u_fa (
      .a_i(a_dig[i]),
      .b_i(b_dig[i]),
      .c_i(chain[i]),
      .s_o(sum_dig[i]),
      .c_o(chain[i+1])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          // The mode is folded into b_eff and carry0, so it needs no register.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? ~cin : cin;
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        for (int unsigned k = 0; k < NDIG; k++) begin
          if (cnt_q == CntW'(k)) begin
            acc_d[k*DIGIT +: DIGIT] = sum_dig;
          end
        end
        carry_d = chain[DIGIT];
        if (cnt_q == LastDig) begin
          s_d     = acc_d;
          cout_d  = chain[DIGIT];
          ovf_d   = chain[DIGIT] ^ chain[DIGIT-1];
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_adder.sv
module tb_seq_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start2, start8;
  logic [7:0] a, b;
  logic       cin, sub;
  logic       busy2, done2, cout2, ovf2;
  logic [7:0] s2;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] s8;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  seq_adder #(.WIDTH(8), .DIGIT(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy2), .done(done2), .s(s2), .cout(cout2), .ovf(ovf2)
  );

  seq_adder #(.WIDTH(8), .DIGIT(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy8), .done(done8), .s(s8), .cout(cout8), .ovf(ovf8)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] s;
    logic       cout;
    logic       ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Reference: whole-word arithmetic; returns {ovf, cout, s}.
  function automatic logic [9:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                       input logic mcin, input logic msub);
    logic [7:0] be;
    int         c0, u, sr;
    be = msub ? ~mb : mb;
    c0 = msub ? int'(!mcin) : int'(mcin);
    u  = int'(ma) + int'(be) + c0;
    sr = int'($signed(ma)) + int'($signed(be)) + c0;
    return {(sr > 127 || sr < -128), (u > 255), u[7:0]};
  endfunction

  task automatic do_op(input bit wide, input logic [7:0] ta, input logic [7:0] tb,
                       input logic tcin, input logic tsub, input logic [7:0] es,
                       input logic ec, input logic eo, input string tag);
    int lat;
    int ndig;
    ndig = wide ? 1 : 4;
    a = ta; b = tb; cin = tcin; sub = tsub;
    if (wide) start8 = 1'b1;
    else start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0; start8 = 1'b0;
    check({tag, " busy"}, wide ? busy8 : busy2, 1);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!(wide ? done8 : done2) && lat < 20);
    check({tag, " latency"}, lat, ndig);
    check({tag, " s"}, wide ? s8 : s2, es);
    check({tag, " cout"}, wide ? cout8 : cout2, ec);
    check({tag, " ovf"}, wide ? ovf8 : ovf2, eo);
    @(posedge clk); #1;
    check({tag, " done one cycle"}, wide ? done8 : done2, 0);
  endtask

  vec_t vecs[8];

  initial begin
    logic [9:0] m;
    logic [7:0] ra, rb;
    logic       rc, rs;
    int         n_done;
    int         lat;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[2] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
    vecs[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0};

    rst = 1'b1; start2 = 1'b0; start8 = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #2;
    check("reset s2", s2, 0);
    check("reset cout2/ovf2", {cout2, ovf2}, 0);
    check("reset busy2/done2", {busy2, done2}, 0);
    check("reset s8/busy8/done8", {s8, busy8, done8}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_op(1'b0, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
            vecs[i].s, vecs[i].cout, vecs[i].ovf, $sformatf("vec%0d d2", i));
      do_op(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
            vecs[i].s, vecs[i].cout, vecs[i].ovf, $sformatf("vec%0d d8", i));
    end

    do_op(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "single digit FF+01");

    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      m  = model(ra, rb, rc, rs);
      do_op(i[0], ra, rb, rc, rs, m[7:0], m[8], m[9], $sformatf("rand%0d", i));
    end

    // Start mid-run is ignored; start held in DONE launches the next op.
    a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    a = 8'hAA; b = 8'h55; cin = 1'b1; sub = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    check("ignore start busy", busy2, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("ignore start done", done2, 1);
    check("ignore start s", s2, 8'h46);
    check("ignore start cout/ovf", {cout2, ovf2}, 0);
    a = 8'h20; b = 8'h03; cin = 1'b0; sub = 1'b0; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    check("b2b busy", {busy2, done2}, 2'b10);
    check("b2b s hold", s2, 8'h46);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done2 && lat < 20);
    check("b2b latency", lat, 4);
    check("b2b s", s2, 8'h23);

    // Reset mid-run aborts with no done pulse.
    @(posedge clk); #1;
    a = 8'h0F; b = 8'h01; cin = 1'b0; sub = 1'b0; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort s", s2, 0);
    check("abort flags", {busy2, done2, cout2, ovf2}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done2) n_done++;
    end
    check("abort no done", n_done, 0);
    do_op(1'b0, 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, "after abort");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
